// File: rtl/mult_arb.sv
// Two-requester round-robin front end for a shared sequential multiplier.
// Accepts one request at a time, waits for the multiplier (with timeout) and returns a response.
`timescale 1ns/1ps
module mult_arb #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 127
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 mult_start,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic                 mult_done,
    input  logic [2*WIDTH-1:0]   mult_product,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 rr_last_q, rr_last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 id_q, id_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 err_q, err_d;
    logic                 win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            prod_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            prod_q    <= prod_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        prod_d    = prod_q;
        err_d     = err_q;
        win       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not win last time goes first.
                    win       = (req0 && req1) ? ~rr_last_q : req1;
                    id_d      = win;
                    rr_last_d = win;
                    a_d       = win ? a1 : a0;
                    b_d       = win ? b1 : b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the timeout cycle still counts as success.
                if (mult_done) begin
                    prod_d  = mult_product;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TMO) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt0        = (state_q == S_START) && !id_q;
    assign gnt1        = (state_q == S_START) &&  id_q;
    assign mult_start  = (state_q == S_START);
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign rsp_err     = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_arb.sv
// Scoreboard bench for mult_arb: driver tasks push expected responses, a monitor pops them,
// and a behavioural multiplier answers mult_start after a programmable delay.
`timescale 1ns/1ps
module tb_mult_arb;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 15;
    localparam int PW      = 2 * WIDTH;

    logic              clk;
    logic              reset;
    logic              req0, req1;
    logic [WIDTH-1:0]  a0, b0, a1, b1;
    logic              gnt0, gnt1;
    logic              mult_start;
    logic [WIDTH-1:0]  mult_a, mult_b;
    logic              mult_done;
    logic [PW-1:0]     mult_product;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [PW-1:0]     rsp_product;
    logic              rsp_err;
    logic              busy;

    mult_arb #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .a0           (a0),
        .b0           (b0),
        .a1           (a1),
        .b1           (b1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_product  (rsp_product),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [PW+1:0] exp_q[$];     // {id, err, product}
    int   ready_mode = 0;        // 0 random, 1 hold low, 2 hold high
    int   mult_delay = 1;        // cycles from mult_start to mult_done, <0 = never
    logic model_rr   = 1'b1;     // last winner in the reference model

    task automatic check(input string name, input logic [PW+1:0] act, input logic [PW+1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pick_winner(input int mask, output logic w);
        if (mask == 1)      w = 1'b0;
        else if (mask == 2) w = 1'b1;
        else                w = ~model_rr;
        model_rr = w;
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [PW-1:0] wx, wy;
        wx = {{WIDTH{1'b0}}, x};
        wy = {{WIDTH{1'b0}}, y};
        return wx * wy;
    endfunction

    // ---------------- response consumer ----------------
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       rsp_ready = 1'b0;
                2:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- behavioural multiplier ----------------
    initial begin
        logic [WIDTH-1:0] pa, pb;
        int d;
        mult_done    = 1'b0;
        mult_product = '0;
        forever begin
            @(negedge clk);
            if (mult_start === 1'b1) begin
                pa = mult_a;
                pb = mult_b;
                d  = mult_delay;
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    mult_done    = 1'b1;
                    mult_product = {{WIDTH{1'b0}}, pa} * {{WIDTH{1'b0}}, pb};
                    @(negedge clk);
                    mult_done    = 1'b0;
                    mult_product = '0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [PW+1:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                if (gnt0 || gnt1) begin
                    check("gnt_exclusive", gnt0 & gnt1, 0);
                    check("gnt_with_start", mult_start, 1);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rsp_unexpected: got response id=%0d, expected none", rsp_id);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e[PW+1]);
                        check("rsp_err", rsp_err, e[PW]);
                        check("rsp_product", rsp_product, e[PW-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 4 * TIMEOUT + 60) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid !== 1'b1 && n < TIMEOUT + 10);
    endtask

    // Called at a negedge with the DUT idle; runs one full transaction.
    task automatic txn(input int mask, input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                       input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1, input int d);
        logic w;
        logic e;
        logic [PW-1:0] p;
        int n;
        req0 = mask[0];
        req1 = mask[1];
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        mult_delay = d;
        pick_winner(mask, w);
        if (d < 0) begin
            p = '0;
            e = 1'b1;
        end else begin
            p = w ? ref_mul(x1, y1) : ref_mul(x0, y0);
            e = 1'b0;
        end
        exp_q.push_back({w, e, p});
        @(negedge clk);
        check("gnt0", gnt0, !w);
        check("gnt1", gnt1, w);
        check("mult_a", mult_a, w ? x1 : x0);
        check("mult_b", mult_b, w ? y1 : y0);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_rsp(n);
        check("rsp_latency", n, (d < 0) ? TIMEOUT + 2 : d + 1);
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic w;
        int   n;
        int   seen;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_mult_start", mult_start, 0);
        check("rst_mult_a", mult_a, 0);
        check("rst_mult_b", mult_b, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_product", rsp_product, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Contention: both held for three transactions, order from reset is 0,1,0.
        req0 = 1'b1; req1 = 1'b1;
        a0 = 32'd21; b0 = 32'd2; a1 = 32'd6; b1 = 32'd7;
        mult_delay = 2;
        for (int i = 0; i < 3; i++) begin
            int k;
            pick_winner(3, w);
            exp_q.push_back({w, 1'b0, w ? ref_mul(a1, b1) : ref_mul(a0, b0)});
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(gnt0 || gnt1) && k < 4 * TIMEOUT + 60);
            check("cont_gnt_order", {gnt1, gnt0}, w ? 2'b10 : 2'b01);
            if (i == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        wait_idle();

        // Single request 3*5, done 4 cycles after start.
        txn(1, 32'd3, 32'd5, 32'd0, 32'd0, 4);
        // Minimum latency, requester 1.
        txn(2, 32'd0, 32'd0, 32'd1000, 32'd77, 1);
        // Timeout: no completion.
        txn(1, 32'd9, 32'd9, 32'd0, 32'd0, -1);
        // Boundary operands and completion coinciding with timeout.
        txn(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 3);
        txn(2, 32'd0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, TIMEOUT + 1);
        txn(3, 32'd5, 32'd5, 32'd8, 32'd8, TIMEOUT + 1);

        // Back-pressure with req1 pending behind the response.
        ready_mode = 1;
        req0 = 1'b1; a0 = 32'd7; b0 = 32'd9;
        mult_delay = 2;
        pick_winner(1, w);
        exp_q.push_back({1'b0, 1'b0, ref_mul(32'd7, 32'd9)});
        @(negedge clk);
        check("bp_gnt0", gnt0, 1);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 32'd11; b1 = 32'd13;
        wait_rsp(n);
        check("bp_latency", n, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", rsp_valid, 1);
            check("bp_rsp_stable", {rsp_id, rsp_err, rsp_product}, {1'b0, 1'b0, 64'd63});
        end
        pick_winner(2, w);
        exp_q.push_back({1'b1, 1'b0, ref_mul(32'd11, 32'd13)});
        ready_mode = 2;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 0);
        check("bp_release_idle", busy, 0);
        @(negedge clk);
        check("bp_pending_gnt1", gnt1, 1);
        req1 = 1'b0;
        wait_idle();
        ready_mode = 0;

        // Reset in WAIT, late completion afterwards must be ignored.
        req0 = 1'b1; a0 = 32'd4; b0 = 32'd4;
        mult_delay = 8;
        @(negedge clk);
        check("rmid_gnt0", gnt0, 1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rmid_busy", busy, 0);
        check("rmid_rsp_valid", rsp_valid, 0);
        check("rmid_mult_start", mult_start, 0);
        @(negedge clk);
        reset = 1'b0;
        model_rr = 1'b1;
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || busy || mult_start) seen++;
        end
        check("rmid_quiet_after_release", seen, 0);
        txn(3, 32'd2, 32'd3, 32'd4, 32'd5, 2);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            if (r == 0)      d = -1;
            else if (r == 1) d = TIMEOUT + 1;
            else             d = $urandom_range(1, 6);
            txn($urandom_range(1, 3), $urandom(), $urandom(), $urandom(), $urandom(), d);
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 Parameter WIDTH, default 32, operand width; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 127, maximum WAIT cycles before a response is forced with error.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The ports SHALL be, one per line (name, direction, width, meaning):
  clk           in   1          rising-edge clock
  reset         in   1          asynchronous, active-high reset
  req0 / req1   in   1          requester 0/1 multiply request, level
  a0, b0        in   WIDTH      requester 0 multiplicand, multiplier
  a1, b1        in   WIDTH      requester 1 multiplicand, multiplier
  gnt0 / gnt1   out  1          one-cycle accept pulse to requester 0/1
  mult_start    out  1          one-cycle start pulse to shared sequential multiplier
  mult_a        out  WIDTH      operand A to multiplier
  mult_b        out  WIDTH      operand B to multiplier
  mult_done     in   1          multiplier completion pulse
  mult_product  in   2*WIDTH    multiplier result, valid with mult_done
  rsp_valid     out  1          response valid
  rsp_ready     in   1          response consumer ready
  rsp_id        out  1          requester index owning response
  rsp_product   out  2*WIDTH    product returned
  rsp_err       out  1          1 = timeout, product invalid
  busy          out  1          1 when state != IDLE

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, START, WAIT, RESP.
REQ-006 From IDLE with req0 or req1 high, the FSM SHALL capture the winner's operands and index at the clock edge and go to START; with no request it SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: a single requester wins; if both request, the requester other than rr_last wins.
REQ-008 rr_last SHALL update to the winner index at the IDLE->START edge.
REQ-009 In START, the FSM SHALL assert mult_start and the winner's gnt for exactly one cycle, then go to WAIT unconditionally.
REQ-010 gnt0 and gnt1 SHALL never be high in the same cycle, and gnt SHALL be high only in START.
REQ-011 mult_a and mult_b SHALL come from the capture registers and stay stable from START until WAIT exits.
REQ-012 The requester SHALL keep req and operands valid in the IDLE cycle where it wins; it may drop req after seeing gnt, and the requester's req seen in START is ignored.
REQ-013 mult_done SHALL be sampled only in WAIT; mult_done in any other state SHALL be ignored.
REQ-014 In WAIT, a wait counter SHALL clear on entry and increment once per cycle.
REQ-015 In WAIT, if mult_done is high, the FSM SHALL register mult_product unmodified into rsp_product, clear rsp_err and go to RESP.
REQ-016 In WAIT, if the counter equals TIMEOUT and mult_done is low, the FSM SHALL set rsp_err=1 and rsp_product=0 and go to RESP.
REQ-017 If mult_done and the timeout occur in the same cycle, mult_done SHALL win (rsp_err=0).
REQ-018 The counter width SHALL be clog2(TIMEOUT+1), and the counter SHALL never wrap.
REQ-019 In RESP, rsp_valid SHALL be 1, and rsp_id, rsp_product and rsp_err SHALL hold stable until rsp_valid && rsp_ready.
REQ-020 On rsp_valid && rsp_ready, the FSM SHALL return to IDLE, with rsp_valid low the next cycle.
REQ-021 A request pending in that IDLE cycle SHALL be arbitrated normally, so at most one request is accepted every 4 cycles.
REQ-022 Minimum latency SHALL be as follows: request seen in IDLE at cycle T; START at T+1; mult_done at T+2 gives rsp_valid at T+3.

Reset
REQ-023 On reset, the block SHALL force state=IDLE, rr_last=1 (requester 0 wins first tie), and counter, capture registers and rsp_product to 0.
REQ-024 On reset, all outputs (gnt0, gnt1, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_product, rsp_err, busy) SHALL be 0.
REQ-025 Reset mid-operation SHALL abandon the transaction: no response, no further mult_start, and late mult_done is ignored.

Verification
REQ-026 Single request: req0=1, a0=3, b0=5, mult_done 4 cycles after mult_start with product 15 -> gnt0 and mult_start at T+1, rsp_valid with rsp_id=0, rsp_product=15, rsp_err=0.
REQ-027 Contention: req0=req1=1 held for three transactions -> grant order 0,1,0, and gnt0 and gnt1 never both high.
REQ-028 Timeout: mult_done never asserted -> rsp_valid TIMEOUT+1 cycles after WAIT entry, with rsp_err=1 and rsp_product=0.
REQ-029 Back-pressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable; rsp_ready=1 -> IDLE next cycle, and pending req1 granted.
REQ-030 Boundary: a0=b0=all-ones with mult_product=0xFFFFFFFE00000001 -> passed through unmodified; mult_done coinciding with timeout -> rsp_err=0.
REQ-031 Reset mid-op: reset in WAIT, then mult_done pulse after release -> busy=0, rsp_valid stays 0, next request wins by rr_last=1.
